// File: rtl/mlp_stream.sv
// Streaming two-layer MLP: fc1 accumulates P features per input beat, then fc2, then tanh LUT.
// Build option MLP_STREAM_TANH_BYPASS_EN replaces the LUT with a saturated fc2 sum at the output.
module mlp_stream #(
  parameter int unsigned N_IN = 50,
  parameter int unsigned N2   = 10,
  parameter int unsigned P    = 2,
  parameter int unsigned W_X  = 4,
  parameter int unsigned W_K  = 4,
  parameter int unsigned W_H  = 4,
  parameter int unsigned W_Y  = 16,
  parameter int unsigned SH1  = 4,
  parameter int unsigned SH2  = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 in_vld,
  output logic                                 in_rdy,
  input  logic [P-1:0][W_X-1:0]                in_mag,
  input  logic [P-1:0][1:0]                    in_pol,
  input  logic [N2-1:0][N_IN-1:0][W_K-1:0]     w1_mag,
  input  logic [N2-1:0][N_IN-1:0][W_K-1:0]     w1_pol,
  input  logic [N2:0][W_K-1:0]                 w2,
  input  logic [(2**W_K)-1:0][W_Y-1:0]         tanh_lut,
  output logic                                 out_vld,
  input  logic                                 out_rdy,
  output logic [W_Y-1:0]                       out
);

  localparam int unsigned NB  = (N_IN + P - 1) / P;
  localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned KW  = $clog2(N2 + 1);
  localparam int unsigned HW  = (N2 > 1) ? $clog2(N2) : 1;
  localparam int unsigned AW1 = W_X + W_K + 2 + $clog2(N_IN);
  localparam int unsigned AW2 = W_K + W_H + 2 + $clog2(N2 + 1);

  localparam logic signed [AW1-1:0] H_MAX = AW1'((2**W_H) - 1);
  localparam logic signed [63:0] Q_MIN = -(64'sd1 <<< (W_K - 1));
  localparam logic signed [63:0] Q_MAX = (64'sd1 <<< (W_K - 1)) - 64'sd1;
  localparam logic signed [63:0] Y_MIN = -(64'sd1 <<< (W_Y - 1));
  localparam logic signed [63:0] Y_MAX = (64'sd1 <<< (W_Y - 1)) - 64'sd1;

  typedef enum logic [2:0] {IDLE, ACC1, ACT, ACC2, OUT} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [KW-1:0]         kcnt_q, kcnt_d;
  logic signed [AW1-1:0] acc1_q [N2];
  logic signed [AW1-1:0] acc1_d [N2];
  logic signed [AW1-1:0] beat_sum [N2];
  logic [W_H-1:0]        h_q [N2];
  logic [W_H-1:0]        h_d [N2];
  logic signed [AW2-1:0] acc2_q, acc2_d, acc2_term;
  logic [W_Y-1:0]        out_q, out_d, out_res;
  logic                  out_vld_q, out_vld_d;
  logic                  in_rdy_q, in_rdy_d;
  logic                  beat;
  logic signed [AW1-1:0] sh1;
  logic signed [63:0]    s2, sat;
  logic [IW-1:0]         ix;
  logic [HW-1:0]         hix;
  int                    idx;

  assign beat = in_vld && in_rdy_q;

  // Contribution of the current beat's lanes to every hidden neuron
  always_comb begin
    ix  = '0;
    idx = 0;
    for (int n = 0; n < int'(N2); n++) begin
      beat_sum[n] = '0;
      for (int p = 0; p < int'(P); p++) begin
        idx = int'(bcnt_q) * int'(P) + p;
        if (idx < int'(N_IN)) begin
          ix = IW'(idx);
          beat_sum[n] = beat_sum[n]
                      + AW1'($signed(w1_mag[n][ix])) * AW1'($signed({1'b0, in_mag[p]}))
                      + AW1'($signed(w1_pol[n][ix])) * AW1'($signed(in_pol[p]));
        end
      end
    end
  end

  // fc2 step: weighted hidden activation, or the bias on the final step
  always_comb begin
    hix = '0;
    if (kcnt_q < KW'(N2)) begin
      hix       = HW'(kcnt_q);
      acc2_term = AW2'($signed(w2[kcnt_q])) * AW2'($signed({1'b0, h_q[hix]}));
    end else begin
      acc2_term = AW2'($signed(w2[N2]));
    end
  end

  // Output quantisation from the registered fc2 sum
  always_comb begin
    s2 = 64'(acc2_q >>> SH2);
`ifdef MLP_STREAM_TANH_BYPASS_EN
    if (s2 < Y_MIN)      sat = Y_MIN;
    else if (s2 > Y_MAX) sat = Y_MAX;
    else                 sat = s2;
    out_res = W_Y'(sat);
`else
    if (s2 < Q_MIN)      sat = Q_MIN;
    else if (s2 > Q_MAX) sat = Q_MAX;
    else                 sat = s2;
    out_res = tanh_lut[W_K'(sat)];
`endif
  end

`ifdef MLP_STREAM_TANH_BYPASS_EN
  logic unused_lut;
  assign unused_lut = ^tanh_lut;
`endif

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    kcnt_d    = kcnt_q;
    acc1_d    = acc1_q;
    h_d       = h_q;
    acc2_d    = acc2_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sh1       = '0;
    case (state_q)
      IDLE, ACC1: begin
        if (beat) begin
          for (int n = 0; n < int'(N2); n++) acc1_d[n] = acc1_q[n] + beat_sum[n];
          if (bcnt_q == BW'(NB - 1)) begin
            bcnt_d  = '0;
            acc2_d  = '0;
            state_d = ACT;
          end else begin
            bcnt_d  = bcnt_q + BW'(1);
            state_d = ACC1;
          end
        end
      end
      ACT: begin
        for (int n = 0; n < int'(N2); n++) begin
          sh1 = acc1_q[n] >>> SH1;
          if (sh1[AW1-1])      h_d[n] = '0;
          else if (sh1 > H_MAX) h_d[n] = '1;
          else                 h_d[n] = W_H'(sh1);
        end
        kcnt_d  = '0;
        state_d = ACC2;
      end
      ACC2: begin
        acc2_d = acc2_q + acc2_term;
        kcnt_d = kcnt_q + KW'(1);
        if (kcnt_q == KW'(N2)) state_d = OUT;
      end
      OUT: begin
        // First OUT cycle quantises the settled sum; later cycles hold for the handshake
        if (!out_vld_q) begin
          out_vld_d = 1'b1;
          out_d     = out_res;
        end else if (out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = IDLE;
          for (int n = 0; n < int'(N2); n++) acc1_d[n] = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_rdy_d = (state_d == IDLE) || (state_d == ACC1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      kcnt_q    <= '0;
      acc2_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b0;
      for (int n = 0; n < int'(N2); n++) begin
        acc1_q[n] <= '0;
        h_q[n]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      kcnt_q    <= kcnt_d;
      acc2_q    <= acc2_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      in_rdy_q  <= in_rdy_d;
      acc1_q    <= acc1_d;
      h_q       <= h_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = out_vld_q;
  assign out     = out_q;

endmodule

// File: tb/tb_mlp_stream.sv
// Bench for mlp_stream: directed small-network case plus randomized frames against an arithmetic model.
// Expected output follows MLP_STREAM_TANH_BYPASS_EN when the bench is built with it.
module tb_mlp_stream;

  localparam int N_IN = 50;
  localparam int P    = 2;
  localparam int N2   = 10;
  localparam int NB   = (N_IN + P - 1) / P;
  localparam int SH1  = 4;
  localparam int SH2  = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic                          in_vld, in_rdy, out_vld, out_rdy;
  logic [P-1:0][3:0]             in_mag;
  logic [P-1:0][1:0]             in_pol;
  logic [N2-1:0][N_IN-1:0][3:0]  w1_mag, w1_pol;
  logic [N2:0][3:0]              w2;
  logic [15:0][15:0]             lut;
  logic [15:0]                   out_o;

  logic                          s_in_vld, s_in_rdy, s_out_vld, s_out_rdy;
  logic [1:0][3:0]               s_in_mag;
  logic [1:0][1:0]               s_in_pol;
  logic [1:0][2:0][3:0]          s_w1_mag, s_w1_pol;
  logic [2:0][3:0]               s_w2;
  logic [15:0][15:0]             s_lut;
  logic [15:0]                   s_out;

  mlp_stream u_dut (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_mag(in_mag), .in_pol(in_pol), .w1_mag(w1_mag), .w1_pol(w1_pol),
    .w2(w2), .tanh_lut(lut), .out_vld(out_vld), .out_rdy(out_rdy), .out(out_o)
  );

  mlp_stream #(.N_IN(3), .N2(2), .P(2), .SH1(0), .SH2(0)) u_small (
    .clk(clk), .rstn(rstn), .in_vld(s_in_vld), .in_rdy(s_in_rdy),
    .in_mag(s_in_mag), .in_pol(s_in_pol), .w1_mag(s_w1_mag), .w1_pol(s_w1_pol),
    .w2(s_w2), .tanh_lut(s_lut), .out_vld(s_out_vld), .out_rdy(s_out_rdy), .out(s_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  int wm [N2][N_IN];
  int wp [N2][N_IN];
  int w2v [N2+1];
  int lutv [16];
  int fm [N_IN];
  int fp [N_IN];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rand_weights(input bit all_neg);
    for (int n = 0; n < N2; n++)
      for (int i = 0; i < N_IN; i++) begin
        wm[n][i] = all_neg ? -int'($urandom_range(1, 8)) : int'($urandom_range(0, 15)) - 8;
        wp[n][i] = all_neg ? -int'($urandom_range(1, 8)) : int'($urandom_range(0, 15)) - 8;
        w1_mag[n][i] = 4'(wm[n][i]);
        w1_pol[n][i] = 4'(wp[n][i]);
      end
    for (int k = 0; k <= N2; k++) begin
      w2v[k] = int'($urandom_range(0, 15)) - 8;
      w2[k]  = 4'(w2v[k]);
    end
    for (int j = 0; j < 16; j++) begin
      lutv[j] = int'($urandom_range(0, 65535));
      lut[j]  = 16'(lutv[j]);
    end
  endtask

  task automatic rand_frame(input bit pol_nonneg);
    for (int i = 0; i < N_IN; i++) begin
      fm[i] = int'($urandom_range(0, 15));
      fp[i] = pol_nonneg ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3)) - 2;
    end
  endtask

  // Reference: plain integer dot products, floor shifts and clamps
  function automatic int model_out();
    int acc, s, h, acc2, q;
    acc2 = 0;
    for (int n = 0; n < N2; n++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += wm[n][i] * fm[i] + wp[n][i] * fp[i];
      s = acc >>> SH1;
      h = (s < 0) ? 0 : ((s > 15) ? 15 : s);
      acc2 += w2v[n] * h;
    end
    acc2 += w2v[N2];
    s = acc2 >>> SH2;
`ifdef MLP_STREAM_TANH_BYPASS_EN
    return (s < -32768) ? -32768 : ((s > 32767) ? 32767 : s);
`else
    q = (s < -8) ? -8 : ((s > 7) ? 7 : s);
    return lutv[q & 15];
`endif
  endfunction

  task automatic send_beat(input int b, input bit gappy);
    int  to, i;
    bit  rdy_now, accepted;
    for (int p = 0; p < P; p++) begin
      i = b * P + p;
      in_mag[p] = (i < N_IN) ? 4'(fm[i]) : 4'($urandom);
      in_pol[p] = (i < N_IN) ? 2'(fp[i]) : 2'($urandom);
    end
    if (gappy) begin
      in_vld = 1'b0;
      @(posedge clk); #1;
    end
    in_vld   = 1'b1;
    accepted = 1'b0;
    to       = 0;
    while (!accepted && to < 64) begin
      rdy_now = in_rdy;
      @(posedge clk); #1;
      accepted = rdy_now;
      to++;
    end
    in_vld = 1'b0;
    check_eq("beat_accept", longint'(accepted), 1);
  endtask

  task automatic run_frame(input bit gappy, input int stall, input bit vld_in_stall);
    logic [15:0] exp16;
    int cyc;
    bit busy_rdy, unstable;
    exp16 = 16'(model_out());
    for (int b = 0; b < NB; b++) send_beat(b, gappy);
    in_vld   = vld_in_stall;
    cyc      = 0;
    busy_rdy = 1'b0;
    while (!out_vld && cyc < 200) begin
      if (in_rdy) busy_rdy = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", cyc, N2 + 3);
    check_eq("out", longint'(out_o), longint'(exp16));
    check_eq("rdy_low_busy", longint'(busy_rdy), 0);
    unstable = 1'b0;
    for (int s = 0; s < stall; s++) begin
      out_rdy = 1'b0;
      @(posedge clk); #1;
      if (out_o !== exp16 || out_vld !== 1'b1 || in_rdy !== 1'b0) unstable = 1'b1;
    end
    check_eq("stall_hold", longint'(unstable), 0);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check_eq("post_hs_vld", longint'(out_vld), 0);
    check_eq("post_hs_rdy", longint'(in_rdy), 1);
  endtask

  initial begin
    int cyc, cnt;
    logic [15:0] exp_small;

    rstn = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_mag = '0; in_pol = '0;
    s_in_vld = 1'b0; s_out_rdy = 1'b0; s_in_mag = '0; s_in_pol = '0;
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 3; i++) begin
        s_w1_mag[n][i] = 4'd1;
        s_w1_pol[n][i] = 4'd0;
      end
    s_w2[0] = 4'd1; s_w2[1] = 4'd1; s_w2[2] = 4'd0;
    for (int j = 0; j < 16; j++) s_lut[j] = 16'(j);
    rand_weights(1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_rdy", longint'(in_rdy), 0);
    check_eq("rst_out_vld", longint'(out_vld), 0);
    check_eq("rst_out", longint'(out_o), 0);
    check_eq("rst_s_in_rdy", longint'(s_in_rdy), 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_eq("rdy_after_rst", longint'(in_rdy), 1);

    // Small network: h={6,6}, acc2=12 -> index clamps to 7
    check_eq("s_rdy", longint'(s_in_rdy), 1);
    s_in_mag[0] = 4'd3; s_in_mag[1] = 4'd2; s_in_vld = 1'b1;
    @(posedge clk); #1;
    s_in_mag[0] = 4'd1; s_in_mag[1] = 4'd15; s_in_pol[1] = 2'($urandom);
    @(posedge clk); #1;
    s_in_vld = 1'b0;
    cyc = 0;
    while (!s_out_vld && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
`ifdef MLP_STREAM_TANH_BYPASS_EN
    exp_small = 16'd12;
`else
    exp_small = 16'd7;
`endif
    check_eq("s_latency", cyc, 5);
    check_eq("s_out", longint'(s_out), longint'(exp_small));
    s_out_rdy = 1'b1;
    @(posedge clk); #1;
    s_out_rdy = 1'b0;
    check_eq("s_post_hs", longint'(s_out_vld), 0);

    // Same frame back-to-back and with in_vld gaps
    rand_frame(1'b0);
    run_frame(1'b0, 0, 1'b0);
    run_frame(1'b1, 0, 1'b0);

    // Long output stall with in_vld held high
    rand_frame(1'b0);
    run_frame(1'b0, 20, 1'b1);

    // Reset after two beats, then the clean frame
    rand_frame(1'b0);
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_in_rdy", longint'(in_rdy), 0);
    check_eq("midrst_out_vld", longint'(out_vld), 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_rdy_after", longint'(in_rdy), 1);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_vld) cnt++;
      @(posedge clk); #1;
    end
    check_eq("midrst_no_out", cnt, 0);
    run_frame(1'b0, 0, 1'b0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_vld) cnt++;
      @(posedge clk); #1;
    end
    check_eq("single_out", cnt, 0);

    // All-negative fc1 weights: hidden layer clamps to zero, output driven by bias
    rand_weights(1'b1);
    rand_frame(1'b1);
    run_frame(1'b0, 0, 1'b0);

    for (int f = 0; f < 1000; f++) begin
      if (f % 50 == 0) rand_weights(1'b0);
      rand_frame(1'b0);
      run_frame(($urandom % 4) == 0, int'($urandom_range(0, 3)), 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
